vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen_pkg.sv | 21 ++
 rtl/vga_timing_gen_axis_counter.sv | 57 +++++
 rtl/vga_timing_gen.sv | 76 +++++++
 3 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants, pixel width and phase state types.
package VGA_item_pack;

  localparam int unsigned DATA_WIDTH = 12;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCP, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCP, V_BACK} v_state_t;

  // Axis-neutral phase encoding; ordering matches h_state_t and v_state_t.
  typedef enum logic [1:0] {PH_ACT, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One timing axis: position counter plus active/front/sync/back phase FSM.
module vga_axis_counter
  import VGA_item_pack::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [9:0] cnt,
  output logic [1:0] phase,
  output logic       wrap,
  output logic       in_active
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  if (TOTAL > 1024) begin : g_total_too_large
    $error("vga_axis_counter: TOTAL exceeds 10-bit counter range");
  end

  localparam logic [9:0] ACT_END  = 10'(ACTIVE - 1);
  localparam logic [9:0] FP_END   = 10'(ACTIVE + FP - 1);
  localparam logic [9:0] SYNC_END = 10'(ACTIVE + FP + SYNC - 1);
  localparam logic [9:0] LAST     = 10'(TOTAL - 1);

  phase_t state, state_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      state <= PH_ACT;
    end else if (step) begin
      cnt   <= (cnt == LAST) ? '0 : cnt + 10'd1;
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      PH_ACT:   if (cnt == ACT_END)  state_nx = PH_FRONT;
      PH_FRONT: if (cnt == FP_END)   state_nx = PH_SYNC;
      PH_SYNC:  if (cnt == SYNC_END) state_nx = PH_BACK;
      PH_BACK:  if (cnt == LAST)     state_nx = PH_ACT;
      default:                       state_nx = PH_ACT;
    endcase
  end

  assign phase     = state;
  assign wrap      = step && (cnt == LAST);
  assign in_active = (cnt < 10'(ACTIVE));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, registered RGB444 and active-low syncs.
module vga_timing_gen
  import VGA_item_pack::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [9:0]            pixel_x,
  output logic [9:0]            pixel_y,
  output logic                  active,
  output logic [3:0]            red,
  output logic [3:0]            green,
  output logic [3:0]            blue,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start
);

  logic       h_wrap, v_wrap, h_act, v_act;
  logic [1:0] h_phase, v_phase;
  h_state_t   h_state;
  v_state_t   v_state;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .step(pix_en),
    .cnt(pixel_x), .phase(h_phase), .wrap(h_wrap), .in_active(h_act)
  );

  // The vertical axis steps only on the last pixel of a line.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .step(h_wrap),
    .cnt(pixel_y), .phase(v_phase), .wrap(v_wrap), .in_active(v_act)
  );

  assign h_state     = h_state_t'(h_phase);
  assign v_state     = v_state_t'(v_phase);
  assign active      = h_act && v_act;
  assign frame_start = rst_n && v_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_en) begin
      if (active) begin
        red   <= data_in[11:8];
        green <= data_in[7:4];
        blue  <= data_in[3:0];
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
      hsync <= (h_state != H_SYNCP);
      vsync <= (v_state != V_SYNCP);
    end
  end

endmodule
